reg_bank_write: RTL and testbench
=================================

REG_BANK_WRITE -- requirements
Module: reg_bank_write

Interface
REQ-001 Parameters SHALL be, one per line:
  - WIDTH, 16, datapath width of bus and every register.
  - PC_RST, 16'h0000, PC value after reset.
REQ-002 Ports SHALL be as follows; clock and reset are listed first:
  - clk  in  1  single system clock, rising edge.
  - rst_n  in  1  reset, asynchronous, active-low.
  - bus_in  in  WIDTH  shared bus value to be written.
  - wr_sel  in  4  destination code, same encoding as the bus source select.
  - wr_en  in  1  write strobe, one write per cycle.
  - mem_data  in  WIDTH  memory read data.
  - dr_mem_ld  in  1  load DR from mem_data.
  - inc_pc  in  1  PC increment request.
  - inc_r1  in  1  R1 increment request.
  - inc_r2  in  1  R2 increment request.
  - clr_ac  in  1  AC clear request.
  - dr, r1, r2, r3, ra, rb, rc, rd, ac, pc  out  WIDTH each  registered register contents.
  - z_flag  out  1  registered, AC == 0.
  - wr_err  out  1  sticky, illegal destination written.
  - wr_busy  out  1  pulse, write accepted this cycle.

Function
REQ-003 Destination codes SHALL be:
  - RA 0000, RB 0001, RC 0010, R1 0011, R2 0100, R3 0101, DR 0110, RD 0111, AC 1001, PC 1010.
  - Codes 1000 and 1011-1111 are illegal.
REQ-004 With wr_en=1 and a legal wr_sel, the selected register SHALL take bus_in at the next rising clk edge; latency is 1 cycle and no other register changes.
REQ-005 With wr_en=1 and an illegal wr_sel, no register SHALL change, and wr_err SHALL set and hold until reset.
REQ-006 wr_busy SHALL be 1 for exactly the cycle after any wr_en=1 cycle, legal or illegal.
REQ-007 Each increment request SHALL add 1 modulo 2^WIDTH, so FFFF wraps to 0000 with no flag.
REQ-008 clr_ac SHALL load AC with 0.
REQ-009 Per-register priority, highest first, SHALL be:
  - PC: bus write, then inc_pc.
  - R1: bus write, then inc_r1.
  - R2: bus write, then inc_r2.
  - AC: clr_ac, then bus write.
  - DR: dr_mem_ld, then bus write.
  The losing request is dropped and not deferred.
REQ-010 Requests targeting different registers in the same cycle SHALL all take effect in that cycle.
REQ-011 z_flag SHALL equal (ac == 0) of the updated AC value, registered, and SHALL be 1 after reset.
REQ-012 All outputs SHALL come directly from flops; no output is combinational from inputs.
REQ-013 A write whose source is a register's own current output SHALL be a no-op in value and SHALL still pulse wr_busy.

Reset
REQ-014 When rst_n=0, asynchronously:
  - all registers except PC SHALL be 0.
  - pc SHALL be PC_RST.
  - z_flag SHALL be 1.
  - wr_err and wr_busy SHALL be 0.
REQ-015 Reset asserted mid-cycle SHALL discard any pending request; the first update SHALL occur on the first rising edge with rst_n=1.

Structure
REQ-016 The 4-bit destination codes, the illegal-code check and WIDTH SHALL live in shared package proc_pkg, used by both the bus source select and this block.
REQ-017 The block SHALL instantiate sub-module gp_reg (ports: load, load_data, inc, clr) once per register.
  - Priority resolution per REQ-009 stays in reg_bank_write.
  - gp_reg applies clr > load > inc.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
  - Reset, then wr_en=1, wr_sel=1001, bus_in=1234 -> next cycle ac=1234, z_flag=0, wr_busy=1, all others 0.
  - pc=FFFF, inc_pc=1 for one cycle -> pc=0000, wr_err=0.
  - Same cycle: wr_en=1, wr_sel=1010, bus_in=0040, inc_pc=1 -> pc=0040.
  - Same cycle: dr_mem_ld=1, mem_data=AAAA, wr_en=1, wr_sel=0110, bus_in=5555 -> dr=AAAA.
  - wr_en=1, wr_sel=1100 -> all registers unchanged, wr_err=1 and held for 10 further cycles.
  - Write rb=0007, then assert rst_n=0 asynchronously mid-cycle -> rb=0 and pc=PC_RST immediately, before the next clk edge.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared processor definitions: datapath width and the 4-bit register
// destination/source codes used by both the bus source select and the
// register bank write port.
package proc_pkg;

  localparam int WIDTH = 16;

  typedef enum logic [3:0] {
    DST_RA = 4'b0000,
    DST_RB = 4'b0001,
    DST_RC = 4'b0010,
    DST_R1 = 4'b0011,
    DST_R2 = 4'b0100,
    DST_R3 = 4'b0101,
    DST_DR = 4'b0110,
    DST_RD = 4'b0111,
    DST_AC = 4'b1001,
    DST_PC = 4'b1010
  } dest_e;

  // 1000 and 1011-1111 do not name a register.
  function automatic logic is_legal_dest(input logic [3:0] code);
    logic legal;
    legal = 1'b0;
    case (code)
      DST_RA, DST_RB, DST_RC, DST_R1, DST_R2,
      DST_R3, DST_DR, DST_RD, DST_AC, DST_PC: legal = 1'b1;
      default:                                legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/gp_reg.sv
// General-purpose register with clear, parallel load and increment.
// Local priority is clr > load > inc; increment wraps silently.
module gp_reg #(
  parameter int                 WIDTH   = proc_pkg::WIDTH,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  // Register update: async reset to RST_VAL, then clr > load > inc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (inc) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/reg_bank_write.sv
// Register bank write port: decodes the bus destination code, resolves
// per-register request priority and drives one gp_reg per register.
// Status outputs (z_flag, wr_err, wr_busy) are registered alongside.
module reg_bank_write #(
  parameter int               WIDTH  = proc_pkg::WIDTH,
  parameter logic [WIDTH-1:0] PC_RST = 16'h0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bus_in,
  input  logic [3:0]       wr_sel,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] mem_data,
  input  logic             dr_mem_ld,
  input  logic             inc_pc,
  input  logic             inc_r1,
  input  logic             inc_r2,
  input  logic             clr_ac,
  output logic [WIDTH-1:0] dr,
  output logic [WIDTH-1:0] r1,
  output logic [WIDTH-1:0] r2,
  output logic [WIDTH-1:0] r3,
  output logic [WIDTH-1:0] ra,
  output logic [WIDTH-1:0] rb,
  output logic [WIDTH-1:0] rc,
  output logic [WIDTH-1:0] rd,
  output logic [WIDTH-1:0] ac,
  output logic [WIDTH-1:0] pc,
  output logic             z_flag,
  output logic             wr_err,
  output logic             wr_busy
);

  import proc_pkg::*;

  logic wr_ra, wr_rb, wr_rc, wr_r1, wr_r2, wr_r3, wr_dr, wr_rd, wr_ac, wr_pc;
  logic wr_illegal;

  logic             pc_inc, r1_inc, r2_inc, ac_load, dr_load;
  logic [WIDTH-1:0] dr_data;
  logic [WIDTH-1:0] ac_next;

  // Destination decode; an illegal code matches no register.
  always_comb begin
    wr_ra      = wr_en && (wr_sel == DST_RA);
    wr_rb      = wr_en && (wr_sel == DST_RB);
    wr_rc      = wr_en && (wr_sel == DST_RC);
    wr_r1      = wr_en && (wr_sel == DST_R1);
    wr_r2      = wr_en && (wr_sel == DST_R2);
    wr_r3      = wr_en && (wr_sel == DST_R3);
    wr_dr      = wr_en && (wr_sel == DST_DR);
    wr_rd      = wr_en && (wr_sel == DST_RD);
    wr_ac      = wr_en && (wr_sel == DST_AC);
    wr_pc      = wr_en && (wr_sel == DST_PC);
    wr_illegal = wr_en && !is_legal_dest(wr_sel);
  end

  // Per-register priority; the losing request is simply dropped.
  always_comb begin
    pc_inc  = inc_pc & ~wr_pc;
    r1_inc  = inc_r1 & ~wr_r1;
    r2_inc  = inc_r2 & ~wr_r2;
    ac_load = wr_ac & ~clr_ac;
    dr_load = dr_mem_ld | wr_dr;
    dr_data = dr_mem_ld ? mem_data : bus_in;
    ac_next = ac;
    if (clr_ac) begin
      ac_next = '0;
    end else if (wr_ac) begin
      ac_next = bus_in;
    end
  end

  gp_reg #(.WIDTH(WIDTH), .RST_VAL('0)) u_ra (
    .clk(clk), .rst_n(rst_n), .load(wr_ra), .load_data(bus_in),
    .inc(1'b0), .clr(1'b0), .q(ra)
  );

  gp_reg #(.WIDTH(WIDTH), .RST_VAL('0)) u_rb (
    .clk(clk), .rst_n(rst_n), .load(wr_rb), .load_data(bus_in),
    .inc(1'b0), .clr(1'b0), .q(rb)
  );

  gp_reg #(.WIDTH(WIDTH), .RST_VAL('0)) u_rc (
    .clk(clk), .rst_n(rst_n), .load(wr_rc), .load_data(bus_in),
    .inc(1'b0), .clr(1'b0), .q(rc)
  );

  gp_reg #(.WIDTH(WIDTH), .RST_VAL('0)) u_r1 (
    .clk(clk), .rst_n(rst_n), .load(wr_r1), .load_data(bus_in),
    .inc(r1_inc), .clr(1'b0), .q(r1)
  );

  gp_reg #(.WIDTH(WIDTH), .RST_VAL('0)) u_r2 (
    .clk(clk), .rst_n(rst_n), .load(wr_r2), .load_data(bus_in),
    .inc(r2_inc), .clr(1'b0), .q(r2)
  );

  gp_reg #(.WIDTH(WIDTH), .RST_VAL('0)) u_r3 (
    .clk(clk), .rst_n(rst_n), .load(wr_r3), .load_data(bus_in),
    .inc(1'b0), .clr(1'b0), .q(r3)
  );

  gp_reg #(.WIDTH(WIDTH), .RST_VAL('0)) u_dr (
    .clk(clk), .rst_n(rst_n), .load(dr_load), .load_data(dr_data),
    .inc(1'b0), .clr(1'b0), .q(dr)
  );

  gp_reg #(.WIDTH(WIDTH), .RST_VAL('0)) u_rd (
    .clk(clk), .rst_n(rst_n), .load(wr_rd), .load_data(bus_in),
    .inc(1'b0), .clr(1'b0), .q(rd)
  );

  gp_reg #(.WIDTH(WIDTH), .RST_VAL('0)) u_ac (
    .clk(clk), .rst_n(rst_n), .load(ac_load), .load_data(bus_in),
    .inc(1'b0), .clr(clr_ac), .q(ac)
  );

  gp_reg #(.WIDTH(WIDTH), .RST_VAL(PC_RST)) u_pc (
    .clk(clk), .rst_n(rst_n), .load(wr_pc), .load_data(bus_in),
    .inc(pc_inc), .clr(1'b0), .q(pc)
  );

  // Zero flag tracks the value AC is about to take, so it lines up with ac.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_flag <= 1'b1;
    end else begin
      z_flag <= (ac_next == '0);
    end
  end

  // Sticky illegal-destination error and one-cycle write acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err  <= 1'b0;
      wr_busy <= 1'b0;
    end else begin
      wr_busy <= wr_en;
      if (wr_illegal) begin
        wr_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_bank_write.sv
// Directed bench for reg_bank_write with hand-maintained expected values.
module tb_reg_bank_write;

  localparam int          W      = 16;
  localparam logic [15:0] PC_RST = 16'h0100;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  bus_in;
  logic [3:0]    wr_sel;
  logic          wr_en;
  logic [W-1:0]  mem_data;
  logic          dr_mem_ld, inc_pc, inc_r1, inc_r2, clr_ac;
  logic [W-1:0]  dr, r1, r2, r3, ra, rb, rc, rd, ac, pc;
  logic          z_flag, wr_err, wr_busy;

  logic [W-1:0]  e_dr, e_r1, e_r2, e_r3, e_ra, e_rb, e_rc, e_rd, e_ac, e_pc;
  logic          e_z, e_err, e_busy;

  int checks = 0;
  int errors = 0;

  reg_bank_write #(.WIDTH(W), .PC_RST(PC_RST)) dut (
    .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .wr_sel(wr_sel), .wr_en(wr_en),
    .mem_data(mem_data), .dr_mem_ld(dr_mem_ld), .inc_pc(inc_pc),
    .inc_r1(inc_r1), .inc_r2(inc_r2), .clr_ac(clr_ac),
    .dr(dr), .r1(r1), .r2(r2), .r3(r3), .ra(ra), .rb(rb), .rc(rc), .rd(rd),
    .ac(ac), .pc(pc), .z_flag(z_flag), .wr_err(wr_err), .wr_busy(wr_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string step);
    chk({step, ":ra"}, ra, e_ra);
    chk({step, ":rb"}, rb, e_rb);
    chk({step, ":rc"}, rc, e_rc);
    chk({step, ":r1"}, r1, e_r1);
    chk({step, ":r2"}, r2, e_r2);
    chk({step, ":r3"}, r3, e_r3);
    chk({step, ":dr"}, dr, e_dr);
    chk({step, ":rd"}, rd, e_rd);
    chk({step, ":ac"}, ac, e_ac);
    chk({step, ":pc"}, pc, e_pc);
    chk({step, ":z_flag"}, {15'd0, z_flag}, {15'd0, e_z});
    chk({step, ":wr_err"}, {15'd0, wr_err}, {15'd0, e_err});
    chk({step, ":wr_busy"}, {15'd0, wr_busy}, {15'd0, e_busy});
  endtask

  task automatic idle_inputs();
    bus_in    = '0;
    wr_sel    = 4'b0000;
    wr_en     = 1'b0;
    mem_data  = '0;
    dr_mem_ld = 1'b0;
    inc_pc    = 1'b0;
    inc_r1    = 1'b0;
    inc_r2    = 1'b0;
    clr_ac    = 1'b0;
  endtask

  task automatic expect_reset();
    e_ra = '0; e_rb = '0; e_rc = '0; e_r1 = '0; e_r2 = '0;
    e_r3 = '0; e_dr = '0; e_rd = '0; e_ac = '0; e_pc = PC_RST;
    e_z = 1'b1; e_err = 1'b0; e_busy = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] sel, input logic [W-1:0] val);
    idle_inputs();
    wr_en  = 1'b1;
    wr_sel = sel;
    bus_in = val;
    tick();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    expect_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;

    // Write AC, latency one cycle
    bus_write(4'b1001, 16'h1234);
    e_ac = 16'h1234; e_z = 1'b0; e_busy = 1'b1;
    check_all("wr_ac");

    idle_inputs(); tick();
    e_busy = 1'b0;
    check_all("idle1");

    // PC wrap
    bus_write(4'b1010, 16'hFFFF);
    e_pc = 16'hFFFF; e_busy = 1'b1;
    check_all("wr_pc_ffff");

    idle_inputs(); inc_pc = 1'b1; tick();
    e_pc = 16'h0000; e_busy = 1'b0;
    check_all("pc_wrap");

    // Bus write beats inc_pc
    idle_inputs(); wr_en = 1'b1; wr_sel = 4'b1010; bus_in = 16'h0040; inc_pc = 1'b1; tick();
    e_pc = 16'h0040; e_busy = 1'b1;
    check_all("pc_prio");

    // dr_mem_ld beats bus write
    idle_inputs(); dr_mem_ld = 1'b1; mem_data = 16'hAAAA;
    wr_en = 1'b1; wr_sel = 4'b0110; bus_in = 16'h5555; tick();
    e_dr = 16'hAAAA;
    check_all("dr_prio");

    bus_write(4'b0110, 16'h5555);
    e_dr = 16'h5555;
    check_all("wr_dr");

    // clr_ac beats bus write
    idle_inputs(); clr_ac = 1'b1; wr_en = 1'b1; wr_sel = 4'b1001; bus_in = 16'h7777; tick();
    e_ac = 16'h0000; e_z = 1'b1;
    check_all("ac_prio");

    // Requests to different registers in one cycle all land
    idle_inputs(); wr_en = 1'b1; wr_sel = 4'b0011; bus_in = 16'hFFFF;
    inc_r2 = 1'b1; inc_pc = 1'b1; dr_mem_ld = 1'b1; mem_data = 16'h0BAD; tick();
    e_r1 = 16'hFFFF; e_r2 = 16'h0001; e_pc = 16'h0041; e_dr = 16'h0BAD;
    check_all("multi");

    // R1 wraps on increment; R2 bus write beats inc_r2
    idle_inputs(); inc_r1 = 1'b1; wr_en = 1'b1; wr_sel = 4'b0100; bus_in = 16'h0020; inc_r2 = 1'b1; tick();
    e_r1 = 16'h0000; e_r2 = 16'h0020;
    check_all("r1_wrap_r2_prio");

    bus_write(4'b0000, 16'h00A5);
    e_ra = 16'h00A5;
    check_all("wr_ra");

    bus_write(4'b0111, 16'h0D0D);
    e_rd = 16'h0D0D;
    check_all("wr_rd");

    bus_write(4'b0101, 16'h3333);
    e_r3 = 16'h3333;
    check_all("wr_r3");

    bus_write(4'b0010, 16'h0C0C);
    e_rc = 16'h0C0C;
    check_all("wr_rc");

    // Self write: value unchanged, still acknowledged
    bus_write(4'b0000, 16'h00A5);
    check_all("self_wr");

    bus_write(4'b1001, 16'h0001);
    e_ac = 16'h0001; e_z = 1'b0;
    check_all("wr_ac_1");

    idle_inputs(); clr_ac = 1'b1; tick();
    e_ac = 16'h0000; e_z = 1'b1; e_busy = 1'b0;
    check_all("clr_ac");

    // Illegal destination: nothing changes, error sticks
    bus_write(4'b1100, 16'hFFFF);
    e_err = 1'b1; e_busy = 1'b1;
    check_all("illegal_c");

    idle_inputs();
    e_busy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_all("err_hold");
    end

    bus_write(4'b1000, 16'h1111);
    e_busy = 1'b1;
    check_all("illegal_8");

    // Async reset mid-cycle
    bus_write(4'b0001, 16'h0007);
    e_rb = 16'h0007;
    check_all("wr_rb");

    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    expect_reset();
    check_all("async_rst");

    // Request held through reset must not land until reset releases
    wr_en = 1'b1; wr_sel = 4'b0010; bus_in = 16'h1111;
    tick();
    check_all("rst_held");

    #2;
    rst_n = 1'b1;
    tick();
    e_rc = 16'h1111; e_busy = 1'b1;
    check_all("post_rst_wr");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
